// File: rtl/micro_sequencer.sv
// ---------------------------------------------------------------------------
// micro_sequencer
// Walks a 16-word microroutine in an external control store. The routine
// base is {opcode, 4'h0}. Each word is fetched in two cycles (FETCH issues
// the read, DECODE consumes the returned word). The datapath may stall
// consumption in DECODE. A routine ends on a word with END (bit 0) set.
// Reaching the 16th word without END raises a sticky fault.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : run request, sampled only while idle
//   opcode     : routine select (base address = {opcode, 4'h0})
//   stall      : datapath hold, blocks consumption of the current word
//   rom_en     : control store read enable (registered)
//   rom_addr   : control store read address (registered)
//   rom_data   : control store word, valid the cycle after the read edge
//   ctrl       : control field of the last consumed word (registered)
//   ctrl_valid : one-cycle pulse per consumed word
//   busy       : high whenever the sequencer is not idle
//   done       : one-cycle pulse when a routine ends on an END word
//   fault      : sticky, 16 words consumed without END; cleared on start
// ---------------------------------------------------------------------------
module micro_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  opcode,
    input  logic        stall,
    output logic        rom_en,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [14:0] ctrl,
    output logic        ctrl_valid,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2
    } state_t;

    state_t      state_q;
    logic        rom_en_q;
    logic [7:0]  rom_addr_q;
    logic [14:0] ctrl_q;
    logic        ctrl_valid_q;
    logic        busy_q;
    logic        done_q;
    logic        fault_q;
    logic [3:0]  step_q;

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= 8'h00;
            ctrl_q       <= 15'h0000;
            ctrl_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            step_q       <= 4'h0;
        end else begin
            // Pulse outputs drop unless a word is consumed this cycle.
            ctrl_valid_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rom_addr_q <= {opcode, 4'h0};
                        rom_en_q   <= 1'b1;
                        step_q     <= 4'h0;
                        fault_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_FETCH;
                    end else begin
                        rom_en_q   <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                S_FETCH: begin
                    // The store samples the read on this edge.
                    rom_en_q <= 1'b0;
                    busy_q   <= 1'b1;
                    state_q  <= S_DECODE;
                end
                S_DECODE: begin
                    if (stall) begin
                        // Hold address and step; the store keeps rom_data stable.
                        rom_en_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end else begin
                        ctrl_q       <= rom_data[15:1];
                        ctrl_valid_q <= 1'b1;
                        if (rom_data[0]) begin
                            // END has priority, so END on the 16th word is a clean finish.
                            done_q   <= 1'b1;
                            rom_en_q <= 1'b0;
                            busy_q   <= 1'b0;
                            state_q  <= S_IDLE;
                        end else if (step_q == 4'hF) begin
                            fault_q  <= 1'b1;
                            rom_en_q <= 1'b0;
                            busy_q   <= 1'b0;
                            state_q  <= S_IDLE;
                        end else begin
                            // Only the low nibble advances so the routine never leaves its block.
                            rom_addr_q <= {rom_addr_q[7:4], rom_addr_q[3:0] + 4'h1};
                            step_q     <= step_q + 4'h1;
                            rom_en_q   <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= S_FETCH;
                        end
                    end
                end
                default: begin
                    rom_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_en     = rom_en_q;
    assign rom_addr   = rom_addr_q;
    assign ctrl       = ctrl_q;
    assign ctrl_valid = ctrl_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// ---------------------------------------------------------------------------
// tb_micro_sequencer
// Self-checking bench: a behavioural model computes, per cycle, the expected
// reads, control pulses, done, busy and fault from the program in the store
// and the stall pattern; each scenario task compares the DUT against it.
// ---------------------------------------------------------------------------
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  opcode;
    logic        stall;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic [14:0] ctrl;
    logic        ctrl_valid;
    logic        busy;
    logic        done;
    logic        fault;

    int tests = 0;
    int fails = 0;

    logic [15:0] mem [256];

    // Per-cycle stall pattern and expected values for one routine.
    bit          stall_a [256];
    bit          x_en    [256];
    logic [7:0]  x_addr  [256];
    bit          x_cv    [256];
    logic [14:0] x_ctrl  [256];
    bit          x_done  [256];
    bit          x_busy  [256];
    bit          x_fault [256];

    // Values carried over between routines.
    logic [14:0] last_ctrl  = 15'h0000;
    bit          last_fault = 1'b0;

    micro_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .opcode     (opcode),
        .stall      (stall),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ctrl       (ctrl),
        .ctrl_valid (ctrl_valid),
        .busy       (busy),
        .done       (done),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Control store: registered read, holds its output while not enabled.
    always @(posedge clk) begin
        if (rom_en) rom_data <= mem[rom_addr];
    end

    task automatic clear_stall();
        for (int i = 0; i < 256; i++) stall_a[i] = 1'b0;
    endtask

    // Reference model: word k is read in cycle f, consumed in the first
    // non-stalled cycle c > f, reported in cycle c+1, and the next read is c+1.
    task automatic model(input logic [3:0] op, output int last);
        int          f;
        int          c;
        int          k;
        bit          fin;
        logic [7:0]  a;
        logic [15:0] w;
        for (int i = 0; i < 256; i++) begin
            x_en[i]    = 1'b0;
            x_addr[i]  = 8'h00;
            x_cv[i]    = 1'b0;
            x_ctrl[i]  = last_ctrl;
            x_done[i]  = 1'b0;
            x_busy[i]  = 1'b0;
            x_fault[i] = (i == 0) ? last_fault : 1'b0;
        end
        f   = 1;
        k   = 0;
        c   = 1;
        w   = 16'h0000;
        fin = 1'b0;
        while (!fin) begin
            a = {op, 4'h0} + 8'(k);
            x_en[f]   = 1'b1;
            x_addr[f] = a;
            c = f + 1;
            while (stall_a[c]) c++;
            for (int i = 1; i <= c; i++) x_busy[i] = 1'b1;
            w = mem[a];
            x_cv[c+1] = 1'b1;
            for (int i = c + 1; i < 256; i++) x_ctrl[i] = w[15:1];
            if (w[0]) begin
                x_done[c+1] = 1'b1;
                fin = 1'b1;
            end else if (k == 15) begin
                for (int i = c + 1; i < 256; i++) x_fault[i] = 1'b1;
                fin = 1'b1;
            end else begin
                k++;
                f = c + 1;
            end
        end
        last       = c + 1;
        last_ctrl  = w[15:1];
        last_fault = x_fault[last];
    endtask

    // Runs one routine from cycle 0 and checks every cycle against the model.
    // inj > 0 pulses start with opcode 5 in that (busy) cycle.
    task automatic run_check(input string name, input logic [3:0] op, input int inj);
        int last;
        model(op, last);
        for (int c = 0; c <= last + 2; c++) begin
            @(negedge clk);
            tests++;
            if (rom_en !== x_en[c]) begin
                fails++;
                $display("FAIL %s rom_en cyc %0d got %b exp %b", name, c, rom_en, x_en[c]);
            end
            if (x_en[c]) begin
                tests++;
                if (rom_addr !== x_addr[c]) begin
                    fails++;
                    $display("FAIL %s rom_addr cyc %0d got %h exp %h", name, c, rom_addr, x_addr[c]);
                end
            end
            if (x_busy[c]) begin
                tests++;
                if (rom_addr[7:4] !== op) begin
                    fails++;
                    $display("FAIL %s addr_block cyc %0d got %h exp block %h", name, c, rom_addr, op);
                end
            end
            tests++;
            if (ctrl_valid !== x_cv[c]) begin
                fails++;
                $display("FAIL %s ctrl_valid cyc %0d got %b exp %b", name, c, ctrl_valid, x_cv[c]);
            end
            tests++;
            if (ctrl !== x_ctrl[c]) begin
                fails++;
                $display("FAIL %s ctrl cyc %0d got %h exp %h", name, c, ctrl, x_ctrl[c]);
            end
            tests++;
            if (done !== x_done[c]) begin
                fails++;
                $display("FAIL %s done cyc %0d got %b exp %b", name, c, done, x_done[c]);
            end
            tests++;
            if (busy !== x_busy[c]) begin
                fails++;
                $display("FAIL %s busy cyc %0d got %b exp %b", name, c, busy, x_busy[c]);
            end
            tests++;
            if (fault !== x_fault[c]) begin
                fails++;
                $display("FAIL %s fault cyc %0d got %b exp %b", name, c, fault, x_fault[c]);
            end
            start  = (c == 0) || (c == inj);
            opcode = (c == 0) ? op : 4'h5;
            stall  = stall_a[c];
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic load_basic();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0008;
        mem[1] = 16'h0004;
        mem[2] = 16'h0301;
    endtask

    task automatic check_all_zero(input string name);
        tests++;
        if ({rom_en, rom_addr, ctrl, ctrl_valid, busy, done, fault} !== 29'h0) begin
            fails++;
            $display("FAIL %s outputs got en=%b addr=%h ctrl=%h cv=%b busy=%b done=%b fault=%b exp all 0",
                     name, rom_en, rom_addr, ctrl, ctrl_valid, busy, done, fault);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        stall  = 1'b0;
        opcode = 4'h0;
        #1;
        check_all_zero("reset_async");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        last_ctrl  = 15'h0000;
        last_fault = 1'b0;
    endtask

    task automatic test_basic();
        load_basic();
        clear_stall();
        run_check("basic", 4'h0, 0);
    endtask

    task automatic test_stall();
        load_basic();
        clear_stall();
        for (int i = 2; i <= 4; i++) stall_a[i] = 1'b1;
        run_check("stall", 4'h0, 0);
    endtask

    task automatic test_busy_start();
        load_basic();
        for (int i = 0; i < 16; i++) mem[8'h50 + 8'(i)] = 16'h7FF1;
        clear_stall();
        run_check("busy_start_a", 4'h0, 2);
        run_check("busy_start_b", 4'h0, 5);
    endtask

    task automatic test_fault();
        for (int i = 0; i < 16; i++) mem[8'h30 + 8'(i)] = 16'($urandom) & 16'hFFFE;
        mem[8'h40] = 16'h0001;
        clear_stall();
        run_check("fault", 4'h3, 0);
        // The following start must clear the sticky fault.
        load_basic();
        run_check("fault_clear", 4'h0, 0);
    endtask

    task automatic test_opcode_f();
        for (int i = 0; i < 15; i++) mem[8'hF0 + 8'(i)] = 16'($urandom) & 16'hFFFE;
        mem[8'hFF] = 16'hA5A5;
        mem[8'h00] = 16'h0001;
        clear_stall();
        for (int i = 3; i < 40; i += 7) stall_a[i] = 1'b1;
        run_check("opcode_f", 4'hF, 0);
    endtask

    task automatic test_reset_mid();
        load_basic();
        clear_stall();
        @(negedge clk);
        start  = 1'b1;
        opcode = 4'h0;
        @(negedge clk);
        start  = 1'b0;
        repeat (3) @(negedge clk);
        // Cycle 4: sequencer is in DECODE (busy, no read pending).
        tests++;
        if (busy !== 1'b1 || rom_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid pre got busy=%b en=%b exp busy=1 en=0", busy, rom_en);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_async");
        @(negedge clk);
        rst_n = 1'b1;
        last_ctrl  = 15'h0000;
        last_fault = 1'b0;
        run_check("reset_mid_rerun", 4'h0, 0);
    endtask

    task automatic test_random();
        logic [3:0] op;
        int         endpos;
        for (int it = 0; it < 40; it++) begin
            op     = 4'($urandom);
            endpos = $urandom_range(0, 19);
            for (int i = 0; i < 16; i++)
                mem[{op, 4'h0} + 8'(i)] = (16'($urandom) & 16'hFFFE) | 16'(i == endpos);
            clear_stall();
            for (int i = 0; i < 150; i++) stall_a[i] = ($urandom_range(0, 3) == 0);
            run_check("random", op, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_busy_start();
        test_fault();
        test_opcode_f();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
